// File: rtl/lane_pkg.sv
// Shared types and constants for the lane receive deframer.
// The optional statistics counters in lane_rx_deframer are built only when
// LANE_RX_STATS_EN is defined.
package lane_pkg;

    localparam int WORD_W = 32;
    // beat_t carries a full bus beat; the deframer's WIDTH must equal BUS_W.
    localparam int BUS_W  = 544;
    localparam int BUS_NW = BUS_W / WORD_W;

    localparam logic [7:0] K_SOP  = 8'hFB;
    localparam logic [7:0] K_EOP  = 8'hFD;
    localparam logic [7:0] K_IDLE = 8'hBC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2,
        SKIP = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [BUS_W-1:0]  dat;
        logic [BUS_NW-1:0] keep;
        logic              sop;
        logic              eop;
        logic              err;
    } beat_t;

    // 16-bit counter add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/lane_beat_fifo.sv
// Synchronous beat FIFO with a registered head: the oldest beat always sits in
// a dedicated output register, the remaining DEPTH-1 beats in a circular buffer.
// Callers must only pop when not empty and only push when not full or popping.
module lane_beat_fifo
    import lane_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  beat_t push_beat,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output beat_t head
);

    localparam int BD = DEPTH - 1;
    localparam int PW = $clog2(DEPTH);

    beat_t         mem [BD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] buf_cnt;
    logic          head_vld;
    logic          take;
    logic          buf_has;
    logic          buf_pop;
    logic          buf_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BD - 1)) ? '0 : p + 1'b1;
    endfunction

    // Head slot frees up when empty or being popped; refill from buffer first.
    always_comb begin
        take     = !head_vld || pop;
        buf_has  = (buf_cnt != '0);
        buf_pop  = take && buf_has;
        buf_push = push && !(take && !buf_has);
        full     = head_vld && (buf_cnt == PW'(BD));
        empty    = !head_vld;
    end

    // Head register, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld <= 1'b0;
            head     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            buf_cnt  <= '0;
        end else begin
            if (take) begin
                if (buf_has) begin
                    head     <= mem[rd_ptr];
                    head_vld <= 1'b1;
                end else if (push) begin
                    head     <= push_beat;
                    head_vld <= 1'b1;
                end else begin
                    head     <= '0;
                    head_vld <= 1'b0;
                end
            end
            if (buf_push) wr_ptr <= ptr_inc(wr_ptr);
            if (buf_pop)  rd_ptr <= ptr_inc(rd_ptr);
            buf_cnt <= buf_cnt + PW'(buf_push) - PW'(buf_pop);
        end
    end

    // Buffer storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (buf_push) mem[wr_ptr] <= push_beat;
    end

endmodule

// File: rtl/lane_rx_deframer.sv
// Lane receive deframer: scans each fully valid beat for K-coded SOP/EOP,
// builds a per-word payload keep mask and queues beats in lane_beat_fifo.
// Define LANE_RX_STATS_EN to build pkt_cnt/err_cnt/ovf_cnt; otherwise they read 0.
module lane_rx_deframer
    import lane_pkg::*;
#(
    parameter int LANS  = 4,
    parameter int WIDTH = BUS_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         rdat,
    input  logic [WIDTH/WORD_W-1:0]  rdatk,
    input  logic [LANS-1:0]          rdatv,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [WIDTH-1:0]         out_dat,
    output logic [WIDTH/WORD_W-1:0]  out_keep,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic                     out_err,
    output logic [15:0]              pkt_cnt,
    output logic [15:0]              err_cnt,
    output logic [15:0]              ovf_cnt
);

    localparam int NW = WIDTH / WORD_W;

    rx_state_e   state;
    rx_state_e   scan_st;
    logic [NW-1:0] scan_keep;
    logic        scan_sop, scan_eop, scan_err, scan_pkt;
    logic [4:0]  scan_errs;
    logic        seen_eop, halt;
    logic [7:0]  code;

    logic        acc, need, pop, can_push, push, ovf_evt;
    logic        fifo_full, fifo_empty;
    beat_t       push_beat, head;

    // Walk words 0..NW-1 in order; DROP scans as PKT only to learn whether the beat carried anything.
    always_comb begin
        scan_st   = (state == DROP) ? PKT : state;
        scan_keep = '0;
        scan_sop  = 1'b0;
        scan_eop  = 1'b0;
        scan_err  = 1'b0;
        scan_pkt  = 1'b0;
        scan_errs = '0;
        seen_eop  = 1'b0;
        halt      = 1'b0;
        code      = '0;
        for (int j = 0; j < NW; j++) begin
            code = rdat[j*WORD_W +: 8];
            if (!halt) begin
                case (scan_st)
                    IDLE: begin
                        if (rdatk[j]) begin
                            if (code == K_SOP && !seen_eop) begin
                                scan_st  = PKT;
                                scan_sop = 1'b1;
                            end else if (code != K_IDLE) begin
                                scan_errs = scan_errs + 5'd1;
                                if (code == K_EOP) seen_eop = 1'b1;
                            end
                        end
                    end
                    PKT: begin
                        if (!rdatk[j]) begin
                            scan_keep[j] = 1'b1;
                        end else if (code == K_EOP) begin
                            scan_eop = 1'b1;
                            scan_pkt = 1'b1;
                            seen_eop = 1'b1;
                            scan_st  = IDLE;
                        end else if (code != K_IDLE) begin
                            scan_eop  = 1'b1;
                            scan_err  = 1'b1;
                            scan_errs = scan_errs + 5'd1;
                            scan_st   = IDLE;
                            halt      = 1'b1;
                        end
                    end
                    SKIP: begin
                        if (rdatk[j] && code == K_EOP) begin
                            scan_st = IDLE;
                            halt    = 1'b1;
                        end
                    end
                    default: halt = 1'b1;
                endcase
            end
        end
    end

    // Push/overflow decision; in DROP the only push is the error terminator.
    always_comb begin
        acc      = &rdatv;
        need     = (|scan_keep) | scan_sop | scan_eop;
        pop      = !fifo_empty & out_rdy;
        can_push = !fifo_full | pop;
        if (state == DROP) begin
            push      = can_push;
            push_beat = '{dat: '0, keep: '0, sop: 1'b0, eop: 1'b1, err: 1'b1};
            ovf_evt   = acc & need;
        end else begin
            push      = acc & need & can_push;
            push_beat = '{dat: rdat, keep: scan_keep, sop: scan_sop, eop: scan_eop, err: scan_err};
            ovf_evt   = acc & need & !can_push;
        end
    end

    // Framing state: partial beats leave it alone; losing an open packet enters DROP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (state == DROP) begin
            if (can_push) state <= SKIP;
        end else if (acc) begin
            state <= (ovf_evt && scan_st == PKT) ? DROP : scan_st;
        end
    end

    lane_beat_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign out_vld  = !fifo_empty;
    assign out_dat  = head.dat;
    assign out_keep = head.keep;
    assign out_sop  = head.sop;
    assign out_eop  = head.eop;
    assign out_err  = head.err;

`ifdef LANE_RX_STATS_EN
    // Saturating statistics; a packet counts only once its EOP beat is queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            pkt_cnt <= sat_add16(pkt_cnt, 5'(push & scan_pkt & (state != DROP)));
            err_cnt <= sat_add16(err_cnt, !acc ? 5'd1 : ((state == DROP) ? 5'd0 : scan_errs));
            ovf_cnt <= sat_add16(ovf_cnt, 5'(ovf_evt));
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{scan_pkt, scan_errs};
    assign pkt_cnt = '0;
    assign err_cnt = '0;
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_rx_deframer.sv
// Bench for lane_rx_deframer: directed framing scenarios plus randomized traffic,
// every cycle compared against a queue-based packet model.
module tb_lane_rx_deframer;

    localparam int W     = 544;
    localparam int NW    = W / 32;
    localparam int LANS  = 4;
    localparam int DEPTH = 4;
    localparam int BW    = W + NW + 3;

    localparam logic [7:0] C_SOP  = 8'hFB;
    localparam logic [7:0] C_EOP  = 8'hFD;
    localparam logic [7:0] C_IDLE = 8'hBC;

`ifdef LANE_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [W-1:0]    rdat;
    logic [NW-1:0]   rdatk;
    logic [LANS-1:0] rdatv;
    logic            out_vld;
    logic            out_rdy;
    logic [W-1:0]    out_dat;
    logic [NW-1:0]   out_keep;
    logic            out_sop, out_eop, out_err;
    logic [15:0]     pkt_cnt, err_cnt, ovf_cnt;

    lane_rx_deframer dut (
        .clk(clk), .rst(rst), .rdat(rdat), .rdatk(rdatk), .rdatv(rdatv),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_keep(out_keep),
        .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: expected beats {dat, keep, sop, eop, err} in delivery order
    logic [BW-1:0] exp_q[$];
    bit m_in_pkt, m_drop, m_skip;
    int m_pkt, m_err, m_ovf;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    // Model one clock edge from the current inputs, using packet-level rules.
    task automatic model_step();
        logic [NW-1:0] keep;
        logic [7:0] code;
        bit sop, eop, err, saw_eop, need, pop, can_push, allv;
        pop      = (exp_q.size() != 0) && out_rdy;
        can_push = (exp_q.size() < DEPTH) || pop;
        if (rst) begin
            exp_q.delete();
            m_in_pkt = 0; m_drop = 0; m_skip = 0;
            m_pkt = 0; m_err = 0; m_ovf = 0;
            return;
        end
        if (pop) void'(exp_q.pop_front());
        allv = (rdatv == '1);
        if (m_drop) begin
            need = 0;
            for (int j = 0; j < NW; j++)
                if (!(rdatk[j] && rdat[j*32 +: 8] == C_IDLE)) need = 1;
            if (allv && need) m_ovf++;
            else if (!allv) m_err++;
            if (can_push) begin
                exp_q.push_back({{W{1'b0}}, {NW{1'b0}}, 1'b0, 1'b1, 1'b1});
                m_drop = 0;
                m_skip = 1;
            end
            return;
        end
        if (!allv) begin
            m_err++;
            return;
        end
        if (m_skip) begin
            for (int j = 0; j < NW; j++)
                if (rdatk[j] && rdat[j*32 +: 8] == C_EOP) begin
                    m_skip = 0;
                    break;
                end
            return;
        end
        keep = '0; sop = 0; eop = 0; err = 0; saw_eop = 0;
        for (int j = 0; j < NW; j++) begin
            code = rdat[j*32 +: 8];
            if (!rdatk[j]) begin
                if (m_in_pkt) keep[j] = 1'b1;
            end else if (code == C_IDLE) begin
            end else if (m_in_pkt) begin
                eop = 1; m_in_pkt = 0;
                if (code == C_EOP) saw_eop = 1;
                else begin
                    err = 1; m_err++;
                    break;
                end
            end else if (code == C_SOP && !saw_eop) begin
                m_in_pkt = 1; sop = 1;
            end else begin
                m_err++;
                if (code == C_EOP) saw_eop = 1;
            end
        end
        need = (keep != '0) || sop || eop;
        if (need) begin
            if (can_push) begin
                exp_q.push_back({rdat, keep, sop, eop, err});
                if (eop && !err) m_pkt++;
            end else begin
                m_ovf++;
                if (m_in_pkt) begin
                    m_in_pkt = 0;
                    m_drop = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("out_vld", BW'(out_vld), BW'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("beat", {out_dat, out_keep, out_sop, out_eop, out_err}, exp_q[0]);
        check("pkt_cnt", BW'(pkt_cnt), BW'(STATS ? sat16(m_pkt) : 16'd0));
        check("err_cnt", BW'(err_cnt), BW'(STATS ? sat16(m_err) : 16'd0));
        check("ovf_cnt", BW'(ovf_cnt), BW'(STATS ? sat16(m_ovf) : 16'd0));
    endtask

    // driver tasks: inputs change only after the falling edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic fill_data();
        for (int j = 0; j < NW; j++) rdat[j*32 +: 32] = $urandom;
        rdatk = '0;
        rdatv = '1;
    endtask

    task automatic put_k(input int j, input logic [7:0] c);
        logic [31:0] r;
        r = $urandom;
        rdat[j*32 +: 32] = {r[31:8], c};
        rdatk[j] = 1'b1;
    endtask

    task automatic idle_beat();
        fill_data();
        for (int j = 0; j < NW; j++) put_k(j, C_IDLE);
    endtask

    task automatic do_reset();
        idle_beat();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] pick_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 30) return C_SOP;
        if (r < 60) return C_EOP;
        if (r < 85) return C_IDLE;
        return 8'h55;
    endfunction

    task automatic rand_beat();
        int nk;
        fill_data();
        if ($urandom_range(0, 9) == 0) idle_beat();
        else if ($urandom_range(0, 9) < 6) begin
            nk = $urandom_range(1, 3);
            for (int i = 0; i < nk; i++) put_k($urandom_range(0, NW - 1), pick_code());
        end
        if ($urandom_range(0, 19) == 0) rdatv = LANS'($urandom_range(0, 14));
    endtask

    initial begin
        bit seen_term;
        int rdy_pct;
        rst = 1'b1;
        out_rdy = 1'b0;
        idle_beat();
        do_reset();
        check("rst_vld", BW'(out_vld), BW'(0));
        check("rst_outs", {out_dat, out_keep, out_sop, out_eop, out_err}, BW'(0));
        check("rst_cnts", BW'({pkt_cnt, err_cnt, ovf_cnt}), BW'(0));

        // single packet across two beats
        out_rdy = 1'b1;
        fill_data(); put_k(0, C_SOP); cycle();
        check("t1_keep", BW'(out_keep), BW'(17'h1FFFE));
        check("t1_sop", BW'({out_vld, out_sop, out_eop}), BW'(3'b110));
        fill_data(); put_k(0, C_EOP); cycle();
        check("t1_eop", BW'({out_keep, out_sop, out_eop, out_err}), BW'({17'h0, 3'b010}));
        idle_beat(); cycle();
        check("t1_pkt", BW'(pkt_cnt), BW'(STATS ? 16'd1 : 16'd0));

        // partial-valid beat inside a packet
        do_reset();
        fill_data(); put_k(0, C_SOP); cycle();
        fill_data(); rdatv = 4'b0111; cycle();
        check("t2_err", BW'(err_cnt), BW'(STATS ? 16'd1 : 16'd0));
        fill_data(); cycle();
        check("t2_cont", BW'({out_vld, out_keep, out_sop}), BW'({1'b1, 17'h1FFFF, 1'b0}));

        // whole packet inside one beat
        do_reset();
        fill_data(); put_k(3, C_SOP); put_k(9, C_EOP); cycle();
        check("t3_beat", BW'({out_keep, out_sop, out_eop, out_err}), BW'({17'h001F0, 3'b110}));

        // overflow with consumer stalled, then recovery
        do_reset();
        out_rdy = 1'b0;
        fill_data(); put_k(0, C_SOP); cycle();
        for (int i = 0; i < 5; i++) begin
            fill_data(); cycle();
        end
        check("t4_ovf", BW'(ovf_cnt), BW'(STATS ? 16'd2 : 16'd0));
        out_rdy = 1'b1;
        seen_term = 0;
        for (int i = 0; i < 8; i++) begin
            idle_beat(); cycle();
            if (out_vld && out_eop && out_err && out_keep == '0) seen_term = 1;
        end
        check("t4_term", BW'(seen_term), BW'(1));
        fill_data(); put_k(2, C_EOP); cycle();
        fill_data(); put_k(0, C_SOP); cycle();
        check("t4_resume", BW'({out_vld, out_sop, out_keep}), BW'({2'b11, 17'h1FFFE}));

        // bad K word aborts the packet
        do_reset();
        fill_data(); put_k(0, C_SOP); cycle();
        fill_data(); put_k(5, 8'h55); cycle();
        check("t5_abort", BW'({out_keep, out_sop, out_eop, out_err}), BW'({17'h0001F, 3'b011}));
        check("t5_err", BW'(err_cnt), BW'(STATS ? 16'd1 : 16'd0));

        // reset with beats queued
        do_reset();
        out_rdy = 1'b0;
        fill_data(); put_k(0, C_SOP); cycle();
        fill_data(); cycle();
        fill_data(); cycle();
        idle_beat(); rst = 1'b1; cycle();
        rst = 1'b0;
        check("t6_flush", BW'(out_vld), BW'(0));
        out_rdy = 1'b1;
        fill_data(); put_k(0, C_SOP); cycle();
        check("t6_clean", BW'({out_vld, out_sop, out_eop, out_keep}), BW'({3'b110, 17'h1FFFE}));

        // randomized traffic with varying consumer pressure
        rdy_pct = 70;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) rdy_pct = $urandom_range(10, 100);
            out_rdy = ($urandom_range(1, 100) <= rdy_pct);
            rand_beat();
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
